ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Round-robin arbiter that shares the single data port of the on-chip SRAM (`ram_2p` port A) between several bus hosts, e.g. the Ibex data port and a future accelerator DMA. Each host uses the Ibex-style req/gnt/rvalid protocol. The arbiter grants at most one request per cycle and forwards it to the memory. It then routes the memory's fixed one-cycle response back to the granted host. Requests outside the memory window are answered locally with an error.

## Interface
- `NumHosts`, default 2: number of requesters, 2..8.
- `AddrWidth`, default 32: host address width.
- `DataWidth`, default 32: data width; byte enables are `DataWidth/8` wide.
- `MemStart`, default 32'h00100000: base of the memory window.
- `MemSize`, default 64*1024: window size in bytes; must be a power of two.
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `host_req_i`, in, NumHosts: request per host.
- `host_gnt_o`, out, NumHosts: grant, one-hot or zero.
- `host_we_i`, in, NumHosts: write enable.
- `host_be_i`, in, NumHosts×DataWidth/8: byte enables.
- `host_addr_i`, in, NumHosts×AddrWidth: byte address.
- `host_wdata_i`, in, NumHosts×DataWidth: write data.
- `host_rvalid_o`, out, NumHosts: response valid, one cycle after grant.
- `host_rdata_o`, out, DataWidth: response data, shared by all hosts and qualified by `host_rvalid_o`.
- `host_err_o`, out, 1: response error, qualified by `host_rvalid_o`.
- `mem_req_o`, out, 1: memory request.
- `mem_we_o`, out, 1: memory write enable.
- `mem_be_o`, out, DataWidth/8: memory byte enables.
- `mem_addr_o`, out, AddrWidth: word address (offset >> 2).
- `mem_wdata_o`, out, DataWidth: memory write data.
- `mem_rvalid_i`, in, 1: memory response valid.
- `mem_rdata_i`, in, DataWidth: memory read data.

## Operation
- **Arbitration**
  - Combinational each cycle.
  - Scan hosts starting at the round-robin pointer `rr_q`, wrapping modulo NumHosts; the first host with `host_req_i` set wins.
  - Assert `host_gnt_o[win]` in the same cycle.
- **Pointer update**
  - On any grant, `rr_q` becomes `win+1` modulo NumHosts.
  - With no request, `rr_q` holds.
- **Window check**
  - In range when `(addr & ~(MemSize-1)) == MemStart`.
  - In-range grant: drive `mem_req_o`=1 and the host's we/be/wdata; `mem_addr_o = (addr - MemStart) >> 2`.
  - Out-of-range grant: `mem_req_o` stays 0 and the arbiter answers the request locally as an error.
- **Response tracking**
  - Registers `resp_valid_q`, `resp_idx_q` and `resp_err_q` are loaded on every grant and cleared when there is no grant.
  - In the next cycle, `host_rvalid_o[resp_idx_q]` = `resp_valid_q`.
  - `host_err_o` = `resp_err_q`.
  - `host_rdata_o` = `mem_rdata_i` for an in-range response, 0 for an error.
- **Writes** produce an rvalid exactly like reads, as Ibex requires.
- **Inputs from a non-granted host** are ignored. That host keeps `req` high, per protocol, until granted.
- **Memory rvalid check** (assertion only): `mem_rvalid_i` must equal the registered in-range grant flag. A mismatch is a memory fault.

## Timing
- **Reset values:** `rr_q`=0, `resp_valid_q`=0, `resp_err_q`=0, `resp_idx_q`=0. All of `host_gnt_o`, `host_rvalid_o`, `host_err_o` and `mem_req_o` are 0 while `rst_i` is high.
- **Grant latency:** 0 cycles after the request; the request-to-`mem_req_o` path is combinational.
- **Response latency:** exactly 1 cycle after the grant.
- **Throughput:** one transaction per cycle. Back-to-back grants to the same or different hosts are allowed, because the response slot is freed every cycle.
- **All hosts requesting continuously:** each host is granted once every NumHosts cycles, so starvation is bounded by NumHosts-1 cycles.
- **Reset asserted mid-transaction:** the pending rvalid is dropped. No response is issued after reset is released.

## Structure
- A shared package `ram_arbiter_pkg` holds `MAX_HOSTS` = 8 and the host-index type `host_idx_t` (`logic [2:0]`).
- One sub-module, `rr_arbiter`:
  - Generic N-way round-robin pick.
  - Inputs: request vector and pointer. Outputs: one-hot grant and winner index.
  - Purely combinational; `rr_q` lives in `ram_arbiter`.
- `ram_arbiter` holds the window check, the muxes and the response registers.

## Test plan
- **Single host read:** host0 reads 0x00100010, with the memory model returning 0xDEADBEEF. Expect `gnt[0]` in the same cycle, `mem_addr_o`=4, and `rvalid[0]` with rdata 0xDEADBEEF one cycle later.
- **Contention:** hosts 0 and 1 both hold req for 4 cycles with NumHosts=2, starting from `rr_q`=0. Expect grant order 0,1,0,1, with each host receiving 2 rvalids in order.
- **Out of range:** host1 reads 0x80000000. Expect `gnt[1]`, `mem_req_o`=0, then the next cycle `rvalid[1]`=1, `host_err_o`=1, rdata=0.
- **Write:** host0 writes 0x12345678 with be=4'b0011 to 0x0010FFFC. Expect `mem_we_o`=1, `mem_addr_o`=0x3FFF, be passed through, and an rvalid with err=0 the next cycle.
- **Pointer hold:** with `rr_q`=1, no request for 5 cycles. Then hosts 0 and 1 request together; expect host1 granted first.
- **Reset mid-transaction:** grant host0, then assert `rst_i` in the following cycle. Expect no rvalid, and after release the first grant goes to host0 (`rr_q`=0).

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the SRAM data-port arbiter: host limits, index type
// and the modular increment used by the round-robin scan.
package ram_arbiter_pkg;

    localparam int MAX_HOSTS = 8;

    typedef logic [2:0] host_idx_t;

    // (a + b) mod n for a, b already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? (a + b - n) : (a + b);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin pick: the first requester at or after ptr wins.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  host_idx_t    ptr,
    output logic [N-1:0] gnt,
    output host_idx_t    idx,
    output logic         valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid && req[j] && (wrap_add(int'(ptr), i, N) == j)) begin
                    valid  = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = host_idx_t'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the SRAM data port between Ibex-style req/gnt/rvalid hosts with a
// round-robin grant; requests outside the memory window are answered as errors.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int          NumHosts  = 2,
    parameter int          AddrWidth = 32,
    parameter int          DataWidth = 32,
    parameter logic [31:0] MemStart  = 32'h0010_0000,
    parameter int unsigned MemSize   = 64 * 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumHosts-1:0]             host_req_i,
    output logic [NumHosts-1:0]             host_gnt_o,
    input  logic [NumHosts-1:0]             host_we_i,
    input  logic [NumHosts*DataWidth/8-1:0] host_be_i,
    input  logic [NumHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NumHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NumHosts-1:0]             host_rvalid_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic                            host_err_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int                   BeWidth = DataWidth / 8;
    localparam logic [AddrWidth-1:0] WinMask = ~AddrWidth'(MemSize - 1);
    localparam logic [AddrWidth-1:0] MemBase = AddrWidth'(MemStart);

    host_idx_t             rr_q;
    host_idx_t             win_idx;
    logic [NumHosts-1:0]   arb_gnt;
    logic                  arb_valid;
    logic                  any_gnt;
    logic                  in_range;

    logic                  sel_we;
    logic [BeWidth-1:0]    sel_be;
    logic [AddrWidth-1:0]  sel_addr;
    logic [DataWidth-1:0]  sel_wdata;

    logic                  resp_valid_q;
    logic                  resp_err_q;
    host_idx_t             resp_idx_q;

    rr_arbiter #(.N(NumHosts)) u_rr_arbiter (
        .req   (host_req_i),
        .ptr   (rr_q),
        .gnt   (arb_gnt),
        .idx   (win_idx),
        .valid (arb_valid)
    );

    // Grants are suppressed while reset is high so nothing reaches the memory.
    assign any_gnt    = arb_valid & ~rst_i;
    assign host_gnt_o = rst_i ? '0 : arb_gnt;

    // One-hot AND-OR mux of the winning host's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int h = 0; h < NumHosts; h++) begin
            if (arb_gnt[h]) begin
                sel_we    = host_we_i[h];
                sel_be    = host_be_i[h*BeWidth +: BeWidth];
                sel_addr  = host_addr_i[h*AddrWidth +: AddrWidth];
                sel_wdata = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
    end

    assign in_range    = (sel_addr & WinMask) == MemBase;
    assign mem_req_o   = any_gnt & in_range;
    assign mem_we_o    = sel_we;
    assign mem_be_o    = sel_be;
    assign mem_wdata_o = sel_wdata;
    assign mem_addr_o  = (sel_addr - MemBase) >> 2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_idx_q   <= '0;
        end else if (any_gnt) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            rr_q         <= (win_idx == host_idx_t'(NumHosts - 1)) ? '0 : win_idx + 3'd1;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~in_range;
            resp_idx_q   <= win_idx;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_idx_q   <= '0;
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        for (int h = 0; h < NumHosts; h++) begin
            host_rvalid_o[h] = resp_valid_q && (resp_idx_q == host_idx_t'(h));
        end
    end

    assign host_err_o   = resp_err_q;
    assign host_rdata_o = resp_err_q ? '0 : mem_rdata_i;

    // The memory must answer exactly the in-range grants of the previous cycle.
    mem_rvalid_matches_grant : assert property (
        @(posedge clk_i) disable iff (rst_i) mem_rvalid_i == (resp_valid_q & ~resp_err_q)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a one-cycle SRAM model and a
// scoreboard queue of expected responses.
module tb_ram_arbiter;

    localparam int NH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NH-1:0]     host_req = '0;
    logic [NH-1:0]     host_gnt;
    logic [NH-1:0]     host_we = '0;
    logic [NH*BW-1:0]  host_be = '0;
    logic [NH*AW-1:0]  host_addr = '0;
    logic [NH*DW-1:0]  host_wdata = '0;
    logic [NH-1:0]     host_rvalid;
    logic [DW-1:0]     host_rdata;
    logic              host_err;
    logic              mem_req;
    logic              mem_we;
    logic [BW-1:0]     mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:16383];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .host_req_i    (host_req),
        .host_gnt_o    (host_gnt),
        .host_we_i     (host_we),
        .host_be_i     (host_be),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata),
        .host_err_o    (host_err),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata)
    );

    // SRAM model: fixed one-cycle read latency, reads return pre-write data.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_rvalid <= mem_req;
            if (mem_req) begin
                mem_rdata <= mem[mem_addr[13:0]];
                if (mem_we) begin
                    for (int b = 0; b < BW; b++) begin
                        if (mem_be[b]) mem[mem_addr[13:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return a[31:16] == 16'h0010;
    endfunction

    task automatic set_host(input int h, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        host_we[h]             = we;
        host_be[h*BW +: BW]    = be;
        host_addr[h*AW +: AW]  = addr;
        host_wdata[h*DW +: DW] = wdata;
    endtask

    task automatic check_resp(input string name);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, ":rvalid"}, 32'(host_rvalid), 32'(1) << e.idx);
            check({name, ":err"}, 32'(host_err), 32'(e.err));
            check({name, ":rdata"}, host_rdata, e.rdata);
        end else begin
            check({name, ":no_rvalid"}, 32'(host_rvalid), 32'd0);
        end
    endtask

    // One bus cycle: drive requests at negedge, check grant path, then response.
    task automatic txn(input logic [1:0] req, input logic [1:0] exp_gnt, input string name);
        exp_t        e;
        int          w;
        logic [31:0] a;
        host_req = req;
        #1;
        check({name, ":gnt"}, 32'(host_gnt), 32'(exp_gnt));
        if (exp_gnt != 2'b00) begin
            w = exp_gnt[1] ? 1 : 0;
            a = host_addr[w*AW +: AW];
            check({name, ":mem_req"}, 32'(mem_req), 32'(in_win(a)));
            if (in_win(a)) begin
                check({name, ":mem_addr"}, mem_addr, {18'd0, a[15:2]});
                check({name, ":mem_we"}, 32'(mem_we), 32'(host_we[w]));
                check({name, ":mem_be"}, 32'(mem_be), 32'(host_be[w*BW +: BW]));
                if (host_we[w]) check({name, ":mem_wdata"}, mem_wdata, host_wdata[w*DW +: DW]);
            end
            e.idx   = w;
            e.err   = !in_win(a);
            e.rdata = in_win(a) ? mem[a[15:2]] : 32'd0;
            exp_q.push_back(e);
        end else begin
            check({name, ":mem_req_idle"}, 32'(mem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        check_resp(name);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] req;
        logic [1:0] g;
        int         exp_rr;

        for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0101);
        mem[4] = 32'hDEAD_BEEF;

        // Reset: requests are present but nothing may be granted or answered.
        set_host(0, 1'b0, 4'hF, 32'h0010_0010, 32'd0);
        set_host(1, 1'b0, 4'hF, 32'h0010_0020, 32'd0);
        host_req = 2'b11;
        repeat (2) @(negedge clk);
        check("rst:gnt", 32'(host_gnt), 32'd0);
        check("rst:mem_req", 32'(mem_req), 32'd0);
        check("rst:rvalid", 32'(host_rvalid), 32'd0);
        check("rst:err", 32'(host_err), 32'd0);
        host_req = 2'b00;
        rst = 1'b0;

        // Single host read.
        txn(2'b01, 2'b01, "single_rd");

        // Out of range from host1.
        set_host(1, 1'b0, 4'hF, 32'h8000_0000, 32'd0);
        txn(2'b10, 2'b10, "oor");

        // Contention from rr_q = 0.
        set_host(0, 1'b0, 4'hF, 32'h0010_0020, 32'd0);
        set_host(1, 1'b0, 4'hF, 32'h0010_0040, 32'd0);
        txn(2'b11, 2'b01, "cont0");
        txn(2'b11, 2'b10, "cont1");
        txn(2'b11, 2'b01, "cont2");
        txn(2'b11, 2'b10, "cont3");

        // Write at the top of the window, then read back the merged word.
        set_host(0, 1'b1, 4'b0011, 32'h0010_FFFC, 32'h1234_5678);
        txn(2'b01, 2'b01, "write");
        set_host(0, 1'b0, 4'hF, 32'h0010_FFFC, 32'd0);
        txn(2'b01, 2'b01, "readback");
        check("readback:merged", mem[14'h3FFF][15:0], 32'h5678);

        // Pointer hold with rr_q = 1.
        for (int i = 0; i < 5; i++) txn(2'b00, 2'b00, "idle");
        txn(2'b11, 2'b10, "hold");

        // Random traffic against a reference round-robin model (rr_q = 0 here).
        exp_rr = 0;
        for (int n = 0; n < 40; n++) begin
            for (int h = 0; h < NH; h++) begin
                set_host(h, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | $urandom)
                                                     : (32'h0010_0000 | ($urandom & 32'hFFFC)),
                         $urandom);
            end
            req = 2'($urandom_range(0, 3));
            if (req == 2'b00)      g = 2'b00;
            else if (req[exp_rr])  g = 2'(1 << exp_rr);
            else                   g = 2'(1 << (1 - exp_rr));
            if (g != 2'b00) exp_rr = g[0] ? 1 : 0;
            txn(req, g, "rnd");
        end

        // Reset mid-transaction: the granted response must be dropped.
        set_host(0, 1'b0, 4'hF, 32'h0010_0100, 32'd0);
        set_host(1, 1'b0, 4'hF, 32'h0010_0200, 32'd0);
        host_req = 2'b01;
        #1;
        check("mid_rst:gnt", 32'(host_gnt), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst:gnt_off", 32'(host_gnt), 32'd0);
        check("mid_rst:mem_req_off", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst:no_rvalid", 32'(host_rvalid), 32'd0);
        @(negedge clk);
        host_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst:no_rvalid", 32'(host_rvalid), 32'd0);
        txn(2'b11, 2'b01, "post_rst");
        txn(2'b00, 2'b00, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
